// File: rtl/switch_port_rx.sv
// rtl/switch_port_rx.sv - per-port deframer, target filter and store-and-forward packet FIFO
// Optional trailing XOR checksum check is enabled by defining SWITCH_PORT_RX_ENDCHECK_EN.
module switch_port_rx #(
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_LEN    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [7:0]  pkt_data,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAY, S_DROP_LEN, S_DROP
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
    , S_CHK
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
  logic        busy_q, busy_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [9:0]  out_word_q, out_word_d;
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Each entry is {sop, eop, data}
  logic [9:0]  mem [FIFO_DEPTH];
  logic        wr_en;
  logic [9:0]  wr_word;
  logic [9:0]  rd_word;

  logic [AW:0] used;
  logic [15:0] free, need;
  logic        len_ok, load;
  logic [8:0]  skip_len;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign used    = wr_ptr_q - rd_ptr_q;
  assign free    = 16'(FIFO_DEPTH) - 16'(used);
  assign need    = 16'(rx_data) + 16'd1;
  assign len_ok  = (rx_data != 8'd0) && (16'(rx_data) <= 16'(MAX_LEN)) && (free >= need);
  assign rd_word = mem[rd_ptr_q[AW-1:0]];
  assign load    = (rd_ptr_q != commit_ptr_q) && (!pkt_valid_q || pkt_ready);

`ifdef SWITCH_PORT_RX_ENDCHECK_EN
  // Rejected frames still carry a checksum byte after the payload
  assign skip_len = 9'(rx_data) + 9'd1;
`else
  assign skip_len = 9'(rx_data);
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    wr_en        = 1'b0;
    wr_word      = {2'b00, rx_data};
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
    csum_d       = csum_q;
`endif
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
          csum_d = rx_data;
`endif
          if (rx_data[PORT_ID] && (free != 16'd0)) begin
            wr_en    = 1'b1;
            wr_word  = {2'b10, rx_data};
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = S_LEN;
          end else begin
            drop_count_d = sat_inc(drop_count_q);
            state_d      = S_DROP_LEN;
          end
        end
        S_DROP_LEN: begin
          cnt_d   = skip_len;
          state_d = (skip_len == 9'd0) ? S_IDLE : S_DROP;
        end
        S_LEN: begin
          if (len_ok) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = 9'(rx_data);
            state_d  = S_PAY;
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
            csum_d   = csum_q ^ rx_data;
`endif
          end else begin
            wr_ptr_d     = commit_ptr_q;
            drop_count_d = sat_inc(drop_count_q);
            cnt_d        = skip_len;
            state_d      = (skip_len == 9'd0) ? S_IDLE : S_DROP;
          end
        end
        S_PAY: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q - 9'd1;
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
          csum_d   = csum_q ^ rx_data;
`endif
          if (cnt_q == 9'd1) begin
            wr_word = {2'b01, rx_data};
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
            state_d = S_CHK;
`else
            commit_ptr_d = wr_ptr_q + 1'b1;
            pkt_count_d  = sat_inc(pkt_count_q);
            state_d      = S_IDLE;
`endif
          end
        end
        S_DROP: begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_IDLE;
        end
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
        S_CHK: begin
          if (rx_data == csum_q) begin
            commit_ptr_d = wr_ptr_q;
            pkt_count_d  = sat_inc(pkt_count_q);
          end else begin
            wr_ptr_d     = commit_ptr_q;
            drop_count_d = sat_inc(drop_count_q);
          end
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Output register is refilled whenever it is empty or being consumed
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    pkt_valid_d = pkt_valid_q;
    out_word_d  = out_word_q;
    if (load) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      pkt_valid_d = 1'b1;
      out_word_d  = rd_word;
    end else if (pkt_ready) begin
      pkt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      busy_q       <= 1'b0;
      pkt_valid_q  <= 1'b0;
      out_word_q   <= '0;
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      busy_q       <= busy_d;
      pkt_valid_q  <= pkt_valid_d;
      out_word_q   <= out_word_d;
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  assign pkt_valid  = pkt_valid_q;
  assign pkt_sop    = out_word_q[9];
  assign pkt_eop    = out_word_q[8];
  assign pkt_data   = out_word_q[7:0];
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_switch_port_rx.sv
// tb/tb_switch_port_rx.sv - self-checking bench for switch_port_rx (PORT_ID=2, FIFO_DEPTH=64, MAX_LEN=32)
`timescale 1ns/1ps
module tb_switch_port_rx;
  localparam int PORT_ID    = 2;
  localparam int FIFO_DEPTH = 64;
  localparam int MAX_LEN    = 32;

  logic        clk = 1'b0;
  logic        reset, rx_valid, pkt_valid, pkt_ready, pkt_sop, pkt_eop, busy;
  logic [7:0]  rx_data, pkt_data;
  logic [15:0] pkt_count, drop_count;

  always #5 clk = ~clk;

  switch_port_rx #(.PORT_ID(PORT_ID), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_count(pkt_count),
    .drop_count(drop_count), .busy(busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         exp_pkt = 0;
  int         exp_drop = 0;
  logic [9:0] sb[$];
  bit         rand_ready = 1'b0;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] len;
    bit         ok;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks hold-while-stalled
  initial begin
    bit         stall = 1'b0;
    logic [9:0] stall_word = '0;
    logic [9:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stall_hold", {21'd0, pkt_valid, pkt_sop, pkt_eop, pkt_data}, {21'd0, 1'b1, stall_word});
        if (pkt_valid && pkt_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", {pkt_sop, pkt_eop, pkt_data});
          end else begin
            w = sb.pop_front();
            check("pkt_byte", {22'd0, pkt_sop, pkt_eop, pkt_data}, {22'd0, w});
          end
        end
        stall      = pkt_valid && !pkt_ready;
        stall_word = {pkt_sop, pkt_eop, pkt_data};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) pkt_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] len, input bit ok,
                            input int gap_max, input bit bad_csum);
    logic [7:0] pay[];
    logic [7:0] csum;
    pay  = new[len];
    csum = hdr ^ len;
    for (int i = 0; i < int'(len); i++) begin
      pay[i] = 8'($urandom);
      csum   = csum ^ pay[i];
    end
    if (bad_csum) csum = ~csum;
    if (ok) begin
      sb.push_back({2'b10, hdr});
      sb.push_back({2'b00, len});
      for (int i = 0; i < int'(len); i++) sb.push_back({1'b0, i == int'(len) - 1, pay[i]});
      exp_pkt++;
    end else begin
      exp_drop++;
    end
    send_byte(hdr);
    idle($urandom_range(0, gap_max));
    send_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(pay[i]);
    end
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
    idle($urandom_range(0, gap_max));
    send_byte(csum);
`endif
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_empty"}, {31'd0, pkt_valid}, 0);
    check({name, "_pkt_count"}, {16'd0, pkt_count}, exp_pkt);
    check({name, "_drop_count"}, {16'd0, drop_count}, exp_drop);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t1[5];
    logic [7:0] csum;
    int         n;

    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_pkt_valid", {31'd0, pkt_valid}, 0);
    check("rst_pkt_sop", {31'd0, pkt_sop}, 0);
    check("rst_pkt_eop", {31'd0, pkt_eop}, 0);
    check("rst_pkt_data", {24'd0, pkt_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pkt_count", {16'd0, pkt_count}, 0);
    check("rst_drop_count", {16'd0, drop_count}, 0);
    @(posedge clk);
    #1;

    // Known packet: pkt_valid must rise exactly one cycle after the commit edge
    t1   = '{8'h14, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    csum = 8'h00;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({i == 0, i == 4, t1[i]});
      csum = csum ^ t1[i];
    end
    exp_pkt++;
    send_byte(t1[0]);
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 5; i++) send_byte(t1[i]);
`ifdef SWITCH_PORT_RX_ENDCHECK_EN
    send_byte(csum);
`endif
    @(negedge clk);
    check("t1_valid_commit_cycle", {31'd0, pkt_valid}, 0);
    @(negedge clk);
    check("t1_valid_next_cycle", {31'd0, pkt_valid}, 1);
    @(posedge clk);
    #1;
    wait_drain("t1");

    vecs[0] = '{8'h11, 8'd2,  1'b0};
    vecs[1] = '{8'h34, 8'd4,  1'b1};
    vecs[2] = '{8'h04, 8'd0,  1'b0};
    vecs[3] = '{8'h04, 8'd33, 1'b0};
    vecs[4] = '{8'hF4, 8'd1,  1'b1};
    vecs[5] = '{8'h0B, 8'd5,  1'b0};
    vecs[6] = '{8'h0C, 8'd32, 1'b1};
    vecs[7] = '{8'h04, 8'd31, 1'b1};
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].hdr, vecs[v].len, vecs[v].ok, 1, 1'b0);
      wait_drain($sformatf("vec%0d", v));
    end

    // Fill the FIFO with the consumer stalled; the third packet cannot fit
    pkt_ready = 1'b0;
    send_frame(8'h04, 8'd30, 1'b1, 0, 1'b0);
    send_frame(8'h84, 8'd30, 1'b1, 0, 1'b0);
    send_frame(8'h44, 8'd1,  1'b0, 0, 1'b0);
    @(negedge clk);
    check("full_pkt_count", {16'd0, pkt_count}, exp_pkt);
    check("full_drop_count", {16'd0, drop_count}, exp_drop);
    check("full_head", {22'd0, pkt_valid, pkt_sop, pkt_data}, {22'd0, 1'b1, 1'b1, 8'h04});
    @(posedge clk);
    #1;
    pkt_ready = 1'b1;
    wait_drain("full");

    rand_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      n = 0;
      while (sb.size() > 28 && n < 5000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rand_space", {31'd0, sb.size() <= 28}, 1);
      send_frame({4'($urandom), 4'($urandom) | 4'b0100}, 8'($urandom_range(1, MAX_LEN)), 1'b1, 2, 1'b0);
    end
    rand_ready = 1'b0;
    pkt_ready  = 1'b1;
    wait_drain("rand");

    // Reset in the middle of a payload discards the partial frame and the counters
    send_byte(8'h04);
    send_byte(8'd5);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    reset    = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
    @(negedge clk);
    check("rst2_pkt_valid", {31'd0, pkt_valid}, 0);
    check("rst2_pkt_count", {16'd0, pkt_count}, 0);
    check("rst2_drop_count", {16'd0, drop_count}, 0);
    check("rst2_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    send_frame(8'h24, 8'd5, 1'b1, 1, 1'b0);
    wait_drain("after_rst");

`ifdef SWITCH_PORT_RX_ENDCHECK_EN
    send_frame(8'h04, 8'd3, 1'b0, 0, 1'b1);
    wait_drain("bad_csum");
    send_frame(8'h04, 8'd3, 1'b1, 0, 1'b0);
    wait_drain("good_csum");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
